// File: rtl/mc_residual.sv
// Motion-compensation residual stage: stores the current block and search area,
// then streams the predicted window and signed residual for each received vector.
module mc_residual (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       block_valid,
  input  logic       area_valid,
  input  logic [7:0] in_data,
  input  logic       mv_valid,
  input  logic [2:0] mv_in,
  output logic       out_valid,
  output logic [7:0] out_pred,
  output logic [8:0] out_resid
);

  typedef enum logic [1:0] {IDLE, GOT_X, OUT} state_t;

  state_t     state;
  logic [7:0] blk  [16];
  logic [7:0] area [64];
  logic [3:0] bcnt;
  logic [5:0] acnt;
  logic [2:0] row0;
  logic [2:0] col0;
  logic [3:0] k;

  logic       capture_en;
  logic [2:0] rd_row;
  logic [2:0] rd_col;
  logic [5:0] rd_addr;
  logic [7:0] pred;
  logic [8:0] resid;

  // Components outside -2..+2 saturate to the nearest legal value.
  function automatic logic [2:0] clamp_mv(input logic [2:0] v);
    case (v)
      3'b011:         clamp_mv = 3'b010;
      3'b100, 3'b101: clamp_mv = 3'b110;
      default:        clamp_mv = v;
    endcase
  endfunction

  assign capture_en = (state != OUT);

  // Storage is frozen while a burst is being emitted.
  always_ff @(posedge clk) begin
    if (capture_en) begin
      if (block_valid) begin
        blk[bcnt] <= in_data;
      end else if (area_valid) begin
        area[acnt] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt <= 4'd0;
      acnt <= 6'd0;
    end else begin
      if (!block_valid) begin
        bcnt <= 4'd0;
      end else if (capture_en) begin
        bcnt <= bcnt + 4'd1;
      end
      if (!area_valid) begin
        acnt <= 6'd0;
      end else if (capture_en && !block_valid) begin
        acnt <= acnt + 6'd1;
      end
    end
  end

  // Window origin is at most 4, so row/col plus a 0..3 offset fits in 3 bits.
  assign rd_row  = row0 + {1'b0, k[3:2]};
  assign rd_col  = col0 + {1'b0, k[1:0]};
  assign rd_addr = {rd_row, rd_col};
  assign pred    = area[rd_addr];
  assign resid   = {1'b0, blk[k]} - {1'b0, pred};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      row0      <= 3'd0;
      col0      <= 3'd0;
      k         <= 4'd0;
      out_valid <= 1'b0;
      out_pred  <= 8'd0;
      out_resid <= 9'd0;
    end else begin
      out_valid <= 1'b0;
      out_pred  <= 8'd0;
      out_resid <= 9'd0;
      case (state)
        IDLE: begin
          if (mv_valid) begin
            col0  <= clamp_mv(mv_in) + 3'd2;
            state <= GOT_X;
          end
        end
        GOT_X: begin
          if (mv_valid) begin
            row0  <= 3'd2 - clamp_mv(mv_in);
            k     <= 4'd0;
            state <= OUT;
          end else begin
            state <= IDLE;
          end
        end
        OUT: begin
          out_valid <= 1'b1;
          out_pred  <= pred;
          out_resid <= resid;
          k         <= k + 4'd1;
          if (k == 4'd15) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_residual.sv
// Directed bench for mc_residual: loads block/area data, sends vectors and
// compares each output beat against values derived from the window origin.
module tb_mc_residual;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       block_valid;
  logic       area_valid;
  logic [7:0] in_data;
  logic       mv_valid;
  logic [2:0] mv_in;
  logic       out_valid;
  logic [7:0] out_pred;
  logic [8:0] out_resid;

  int total = 0;
  int bad   = 0;

  logic [7:0] area_m [64];
  logic [7:0] blk_m  [16];
  logic [7:0] first_pred, last_pred;
  logic [8:0] first_resid, last_resid;

  mc_residual dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .block_valid(block_valid),
    .area_valid (area_valid),
    .in_data    (in_data),
    .mv_valid   (mv_valid),
    .mv_in      (mv_in),
    .out_valid  (out_valid),
    .out_pred   (out_pred),
    .out_resid  (out_resid)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic loadBlock();
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      block_valid = 1'b1;
      in_data     = blk_m[i];
    end
    @(negedge clk);
    block_valid = 1'b0;
  endtask

  task automatic loadArea();
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      area_valid = 1'b1;
      in_data    = area_m[i];
    end
    @(negedge clk);
    area_valid = 1'b0;
  endtask

  // Drives the x beat then the y beat; mv_valid is left high for the caller to drop.
  task automatic applyStimulus(input logic [2:0] x, input logic [2:0] y);
    @(negedge clk);
    mv_valid = 1'b1;
    mv_in    = x;
    @(negedge clk);
    mv_in = y;
  endtask

  // ex/ey are the already-legal vector the output should correspond to.
  task automatic runBurst(input logic [2:0] dx, input logic [2:0] dy,
                          input int ex, input int ey, input bit noisy, input string tag);
    int idx;
    logic [7:0] p;
    logic [8:0] r;
    applyStimulus(dx, dy);
    @(negedge clk);
    mv_valid = 1'b0;
    checkOutput({tag, "_pre_valid"}, 32'(out_valid), 32'd0);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      idx = (2 - ey + k / 4) * 8 + (ex + 2) + (k % 4);
      p   = area_m[idx];
      r   = {1'b0, blk_m[k]} - {1'b0, p};
      checkOutput($sformatf("%s_valid%0d", tag, k), 32'(out_valid), 32'd1);
      checkOutput($sformatf("%s_pred%0d", tag, k), 32'(out_pred), 32'(p));
      checkOutput($sformatf("%s_resid%0d", tag, k), 32'(out_resid), 32'(r));
      if (k == 0) begin
        first_pred  = out_pred;
        first_resid = out_resid;
      end
      if (k == 15) begin
        last_pred  = out_pred;
        last_resid = out_resid;
      end
      if (noisy && k < 15) begin
        area_valid = 1'b1;
        in_data    = 8'd7;
      end
    end
    area_valid = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_post_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_post_pred"}, 32'(out_pred), 32'd0);
    checkOutput({tag, "_post_resid"}, 32'(out_resid), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    block_valid = 1'b0;
    area_valid  = 1'b0;
    in_data     = 8'd0;
    mv_valid    = 1'b0;
    mv_in       = 3'd0;
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_pred", 32'(out_pred), 32'd0);
    checkOutput("rst_resid", 32'(out_resid), 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 64; i++) area_m[i] = 8'(i);
    for (int i = 0; i < 16; i++) blk_m[i] = 8'd50;
    loadBlock();
    loadArea();

    runBurst(3'b000, 3'b000, 0, 0, 1'b0, "v00");
    checkOutput("v00_first_pred", 32'(first_pred), 32'd18);
    checkOutput("v00_first_resid", 32'(first_resid), 32'd32);
    checkOutput("v00_last_pred", 32'(last_pred), 32'd45);

    runBurst(3'b110, 3'b010, -2, 2, 1'b0, "vtl");
    checkOutput("vtl_first_pred", 32'(first_pred), 32'd0);
    checkOutput("vtl_last_pred", 32'(last_pred), 32'd27);

    runBurst(3'b010, 3'b110, 2, -2, 1'b0, "vbr");
    checkOutput("vbr_first_pred", 32'(first_pred), 32'd36);
    checkOutput("vbr_last_pred", 32'(last_pred), 32'd63);
    checkOutput("vbr_last_resid", 32'(last_resid), 32'h1F3);

    runBurst(3'b011, 3'b100, 2, -2, 1'b0, "clamp");
    checkOutput("clamp_first_pred", 32'(first_pred), 32'd36);

    // Orphan x beat followed by idle cycles must not start a burst.
    @(negedge clk);
    mv_valid = 1'b1;
    mv_in    = 3'b110;
    @(negedge clk);
    mv_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput($sformatf("orphan_valid%0d", i), 32'(out_valid), 32'd0);
    end
    runBurst(3'b001, 3'b000, 1, 0, 1'b0, "drop");
    checkOutput("drop_first_pred", 32'(first_pred), 32'd19);

    // Reset in the middle of a burst clears outputs without waiting for a clock.
    applyStimulus(3'b000, 3'b000);
    @(negedge clk);
    mv_valid = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("midrst_active", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_pred", 32'(out_pred), 32'd0);
    checkOutput("midrst_resid", 32'(out_resid), 32'd0);
    @(negedge clk);
    checkOutput("midrst_hold", 32'(out_valid), 32'd0);
    rst_n = 1'b1;
    loadBlock();
    loadArea();
    runBurst(3'b000, 3'b000, 0, 0, 1'b0, "postrst");

    for (int i = 0; i < 64; i++) area_m[i] = 8'd255;
    for (int i = 0; i < 16; i++) blk_m[i] = 8'd0;
    loadBlock();
    loadArea();
    runBurst(3'b000, 3'b000, 0, 0, 1'b1, "sat");
    checkOutput("sat_first_resid", 32'(first_resid), 32'h101);
    runBurst(3'b000, 3'b000, 0, 0, 1'b0, "frozen");
    checkOutput("frozen_last_pred", 32'(last_pred), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
